// File: rtl/pu_pkg.sv
// Shared types and constants for the pu_exec_unit slice.
package pu_pkg;

    typedef enum logic [2:0] {
        ADD   = 3'd0,
        AND   = 3'd1,
        NOT   = 3'd2,
        PASSA = 3'd3,
        MUL   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    function automatic logic [2:0] nzp_code(input logic neg, input logic zero);
        if (neg)
            return NZP_N;
        else if (zero)
            return NZP_Z;
        else
            return NZP_P;
    endfunction

endpackage

// File: rtl/pu_regfile.sv
// Register file: two async read ports with write-first forwarding,
// two sync write ports (port 0 has priority), sync reset to zero.
module pu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [AW-1:0]     ra_a,
    output logic [DATA_W-1:0] rd_a,
    input  logic [AW-1:0]     ra_b,
    output logic [DATA_W-1:0] rd_b
);

    logic [DATA_W-1:0] r_mem [NREG];

    // Port 0 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_mem[i] <= '0;
        end else begin
            if (we1)
                r_mem[wa1] <= wd1;
            if (we0)
                r_mem[wa0] <= wd0;
        end
    end

    always_comb begin
        rd_a = r_mem[ra_a];
        if (we0 && wa0 == ra_a)
            rd_a = wd0;
        else if (we1 && wa1 == ra_a)
            rd_a = wd1;
    end

    always_comb begin
        rd_b = r_mem[ra_b];
        if (we0 && wa0 == ra_b)
            rd_b = wd0;
        else if (we1 && wa1 == ra_b)
            rd_b = wd1;
    end

endmodule

// File: rtl/pu_exec_unit.sv
// Register file + operand mux + execute stage with NZP codes.
// Define PU_MUL_EN to build the iterative shift-add multiplier.
module pu_exec_unit
    import pu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int IMM_W  = 5,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [AW-1:0]     in_dr,
    input  logic [AW-1:0]     in_sr1,
    input  logic [AW-1:0]     in_sr2,
    input  logic              in_imm_sel,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_wb_en,
    input  logic              ld_reg,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] from_bus,
    output logic [DATA_W-1:0] sr1_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] to_bus,
    output logic [2:0]        nzp
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [AW-1:0]     r_dr;
    logic              r_wb_en;
    logic [DATA_W-1:0] r_result;
    logic [2:0]        r_nzp;

    logic              w_accept;
    logic              w_wb;
    logic              w_is_mul;
    logic              w_mul_last;
    op_e               w_op;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] w_alu;

    assign w_op      = op_e'(in_op);
    assign w_accept  = in_valid && in_ready;
    assign w_wb      = out_valid && out_ready && r_wb_en && !reset;
    assign w_imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    assign w_opb     = in_imm_sel ? w_imm_ext : w_rd_b;
    assign sr1_out   = w_rd_a;
    assign to_bus    = r_result;
    assign nzp       = r_nzp;

    pu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we0   (w_wb),
        .wa0   (r_dr),
        .wd0   (r_result),
        .we1   (ld_reg),
        .wa1   (ld_addr),
        .wd1   (from_bus),
        .ra_a  (in_sr1),
        .rd_a  (w_rd_a),
        .ra_b  (in_sr2),
        .rd_b  (w_rd_b)
    );

    always_comb begin
        w_alu = w_rd_a;
        case (w_op)
            ADD:     w_alu = w_rd_a + w_opb;
            AND:     w_alu = w_rd_a & w_opb;
            NOT:     w_alu = ~w_rd_a;
            PASSA:   w_alu = w_rd_a;
            MUL:     w_alu = '0;
            default: w_alu = w_rd_a;
        endcase
    end

`ifdef PU_MUL_EN
    localparam int CW = $clog2(DATA_W);
    logic [DATA_W-1:0] r_mul_a;
    logic [DATA_W-1:0] r_mul_b;
    logic [DATA_W-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] w_acc_nxt;

    assign w_is_mul   = (w_op == MUL);
    assign w_mul_last = (r_cnt == CW'(DATA_W-1));
    assign w_acc_nxt  = r_acc + (r_mul_b[0] ? r_mul_a : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_mul_a <= w_rd_a;
            r_mul_b <= w_opb;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_MUL) begin
            r_mul_a <= r_mul_a << 1;
            r_mul_b <= r_mul_b >> 1;
            r_acc   <= w_acc_nxt;
            r_cnt   <= r_cnt + 1'b1;
        end
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (w_mul_last) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dr     <= '0;
            r_wb_en  <= 1'b0;
            r_result <= '0;
            r_nzp    <= NZP_Z;
        end else begin
            if (w_accept) begin
                r_dr     <= in_dr;
                r_wb_en  <= in_wb_en;
                r_result <= w_alu;
            end
`ifdef PU_MUL_EN
            if (r_state == ST_MUL && w_mul_last)
                r_result <= w_acc_nxt;
`endif
            if (w_wb)
                r_nzp <= nzp_code(r_result[DATA_W-1], r_result == '0);
        end
    end

endmodule

// File: tb/tb_pu_exec_unit.sv
// Directed self-checking bench for pu_exec_unit (DATA_W=16, NREG=8, IMM_W=5).
module tb_pu_exec_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_dr;
    logic [2:0]  in_sr1;
    logic [2:0]  in_sr2;
    logic        in_imm_sel;
    logic [4:0]  in_imm;
    logic        in_wb_en;
    logic        ld_reg;
    logic [2:0]  ld_addr;
    logic [15:0] from_bus;
    logic [15:0] sr1_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] to_bus;
    logic [2:0]  nzp;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

`ifdef PU_MUL_EN
    localparam int          MUL_LAT = 17;
    localparam logic [15:0] MUL_RES = 16'h0015;
    localparam logic [2:0]  MUL_NZP = 3'b001;
`else
    localparam int          MUL_LAT = 1;
    localparam logic [15:0] MUL_RES = 16'h0000;
    localparam logic [2:0]  MUL_NZP = 3'b010;
`endif

    pu_exec_unit #(
        .DATA_W (16),
        .NREG   (8),
        .IMM_W  (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_dr      (in_dr),
        .in_sr1     (in_sr1),
        .in_sr2     (in_sr2),
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
        .in_wb_en   (in_wb_en),
        .ld_reg     (ld_reg),
        .ld_addr    (ld_addr),
        .from_bus   (from_bus),
        .sr1_out    (sr1_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .to_bus     (to_bus),
        .nzp        (nzp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [2:0] a, input logic [15:0] d);
        ld_reg = 1'b1; ld_addr = a; from_bus = d;
        tick();
        ld_reg = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
        in_sr1 = a;
        #1;
        check(tag, sr1_out, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] dr, input logic [2:0] s1,
                         input logic [2:0] s2, input logic isel, input logic [4:0] imm,
                         input logic wb);
        in_op = op; in_dr = dr; in_sr1 = s1; in_sr2 = s2;
        in_imm_sel = isel; in_imm = imm; in_wb_en = wb; in_valid = 1'b1;
        #1;
        check("ready_before_issue", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_op = 0; in_dr = 0; in_sr1 = 0; in_sr2 = 0;
        in_imm_sel = 0; in_imm = 0; in_wb_en = 0; ld_reg = 0; ld_addr = 0;
        from_bus = 0; out_ready = 0;
        tick(); tick();
        reset = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_to_bus", to_bus, 0);
        check("rst_nzp", nzp, 3'b010);
        rd("rst_r1", 3'd1, 16'h0000);

        ld(3'd1, 16'h0005);
        ld(3'd2, 16'hFFFD);
        rd("ld_r1", 3'd1, 16'h0005);
        rd("ld_r2", 3'd2, 16'hFFFD);

        // ADD R3 <- R1 + R2
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 5'd0, 1'b1);
        check("add_valid", out_valid, 1);
        check("add_in_ready", in_ready, 0);
        check("add_to_bus", to_bus, 16'h0002);
        handshake();
        check("add_nzp", nzp, 3'b001);
        rd("add_r3", 3'd3, 16'h0002);

        // AND R4 <- R1 & sext(10000)
        issue(3'd1, 3'd4, 3'd1, 3'd0, 1'b1, 5'b10000, 1'b1);
        check("and_to_bus", to_bus, 16'h0000);
        handshake();
        check("and_nzp", nzp, 3'b010);

        // NOT R5 <- ~R1
        issue(3'd2, 3'd5, 3'd1, 3'd0, 1'b0, 5'd0, 1'b1);
        check("not_to_bus", to_bus, 16'hFFFA);
        handshake();
        check("not_nzp", nzp, 3'b100);
        rd("not_r5", 3'd5, 16'hFFFA);

        // Backpressure: ADD R6 <- R1 + 1 held for 5 cycles, competing request ignored
        issue(3'd0, 3'd6, 3'd1, 3'd0, 1'b1, 5'd1, 1'b1);
        in_op = 3'd2; in_dr = 3'd7; in_sr1 = 3'd2; in_wb_en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_to_bus", to_bus, 16'h0006);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        rd("hold_r6_unwritten", 3'd6, 16'h0000);
        // handshake plus external write to a different address
        out_ready = 1'b1; ld_reg = 1'b1; ld_addr = 3'd0; from_bus = 16'h0F0F;
        tick();
        out_ready = 1'b0; ld_reg = 1'b0;
        check("hold_done_in_ready", in_ready, 1);
        check("hold_done_valid", out_valid, 0);
        check("hold_nzp", nzp, 3'b001);
        rd("hold_r6", 3'd6, 16'h0006);
        rd("diff_addr_r0", 3'd0, 16'h0F0F);
        rd("ignored_r7", 3'd7, 16'h0000);

        // Unknown opcode behaves as PASSA; wb_en=0 leaves regs and nzp alone
        issue(3'd7, 3'd7, 3'd2, 3'd0, 1'b0, 5'd0, 1'b0);
        check("passa7_to_bus", to_bus, 16'hFFFD);
        handshake();
        check("nowb_nzp", nzp, 3'b001);
        rd("nowb_r7", 3'd7, 16'h0000);

        // Collision on R3: writeback 0x0002 beats ld_reg 0x1234
        ld(3'd3, 16'h0055);
        rd("pre_coll_r3", 3'd3, 16'h0055);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 5'd0, 1'b1);
        out_ready = 1'b1; ld_reg = 1'b1; ld_addr = 3'd3; from_bus = 16'h1234; in_sr1 = 3'd3;
        #1;
        check("coll_fwd_sr1", sr1_out, 16'h0002);
        tick();
        out_ready = 1'b0; ld_reg = 1'b0;
        rd("coll_r3", 3'd3, 16'h0002);
        check("coll_nzp", nzp, 3'b001);

        // Back-to-back throughput: one op per 2 cycles
        in_op = 3'd0; in_dr = 3'd7; in_sr1 = 3'd1; in_imm_sel = 1'b1; in_imm = 5'd1;
        in_wb_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("b2b_valid", out_valid, (i % 2 == 0) ? 1 : 0);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_to_bus", to_bus, 16'h0006);

        // MUL R4 <- R7 * 7 with R7 = 3
        ld(3'd7, 16'h0003);
        issue(3'd4, 3'd4, 3'd7, 3'd0, 1'b1, 5'd7, 1'b1);
        lat = 1;
        check("mul_in_ready", in_ready, 0);
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("mul_latency", lat, MUL_LAT);
        check("mul_to_bus", to_bus, MUL_RES);
        handshake();
        check("mul_nzp", nzp, MUL_NZP);
        rd("mul_r4", 3'd4, MUL_RES);

        // Reset at cycle 8 of a MUL aborts it and clears state
        issue(3'd4, 3'd4, 3'd7, 3'd0, 1'b1, 5'd7, 1'b1);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_to_bus", to_bus, 16'h0000);
        check("abort_nzp", nzp, 3'b010);
        rd("abort_r1", 3'd1, 16'h0000);
        rd("abort_r3", 3'd3, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
